// File: rtl/cmp_pkg.sv
// Shared types for the wide-operand compare sequencer: FSM state encoding
// and bit positions inside the NZCV flag register.
package cmp_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } cmp_state_e;

  localparam int N_BIT = 3;
  localparam int Z_BIT = 2;
  localparam int C_BIT = 1;
  localparam int V_BIT = 0;

endpackage

// File: rtl/cmp_chunk.sv
// Combinational unsigned compare of one WIDTH-bit chunk; exactly one of
// gt/lt/eq is high for any input pair.
module cmp_chunk #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic             gt,
  output logic             lt,
  output logic             eq
);

  always_comb begin
    gt = (x > y);
    lt = (x < y);
    eq = (x == y);
  end

endmodule

// File: rtl/cmp_sequencer.sv
// Multi-cycle compare of two CHUNKS*WIDTH-bit operands, MSB chunk first,
// through a single chunk comparator; result latched into NZCV flags.
module cmp_sequencer
  import cmp_pkg::*;
#(
  parameter int WIDTH  = 4,
  parameter int CHUNKS = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [WIDTH*CHUNKS-1:0] a_in,
  input  logic [WIDTH*CHUNKS-1:0] b_in,
  input  logic                    signed_cmp,
  input  logic                    abort,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic                    rsp_gt,
  output logic                    rsp_lt,
  output logic                    rsp_eq,
  output logic [3:0]              flags_nzcv
);

  localparam int W  = WIDTH * CHUNKS;
  localparam int IW = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
  localparam logic [IW-1:0] IDX_TOP = IW'(CHUNKS - 1);

  cmp_state_e                     state_q, state_d;
  logic [CHUNKS-1:0][WIDTH-1:0]   opa_q, opa_d;
  logic [CHUNKS-1:0][WIDTH-1:0]   opb_q, opb_d;
  logic [IW-1:0]                  idx_q, idx_d;
  logic                           gt_q, gt_d;
  logic                           lt_q, lt_d;
  logic                           eq_q, eq_d;
  logic [3:0]                     flags_q, flags_d;

  logic c_gt, c_lt, c_eq;

  cmp_chunk #(.WIDTH(WIDTH)) u_chunk (
    .x  (opa_q[idx_q]),
    .y  (opb_q[idx_q]),
    .gt (c_gt),
    .lt (c_lt),
    .eq (c_eq)
  );

  always_comb begin
    state_d = state_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    idx_d   = idx_q;
    gt_d    = gt_q;
    lt_d    = lt_q;
    eq_d    = eq_q;
    flags_d = flags_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          // Flipping both sign bits maps two's complement onto offset binary,
          // so the chunk comparator only ever needs an unsigned compare.
          opa_d = a_in;
          opb_d = b_in;
          opa_d[CHUNKS-1][WIDTH-1] = a_in[W-1] ^ signed_cmp;
          opb_d[CHUNKS-1][WIDTH-1] = b_in[W-1] ^ signed_cmp;
          idx_d   = IDX_TOP;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else if (!c_eq || (idx_q == '0)) begin
          gt_d           = c_gt;
          lt_d           = c_lt;
          eq_d           = c_eq;
          flags_d        = '0;
          flags_d[N_BIT] = c_lt;
          flags_d[Z_BIT] = c_eq;
          flags_d[C_BIT] = 1'b0;
          flags_d[V_BIT] = 1'b0;
          state_d        = ST_DONE;
        end else begin
          idx_d = idx_q - 1'b1;
        end
      end
      ST_DONE: begin
        if (rsp_ready) begin
          gt_d    = 1'b0;
          lt_d    = 1'b0;
          eq_d    = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: begin
        gt_d    = 1'b0;
        lt_d    = 1'b0;
        eq_d    = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      opa_q   <= '0;
      opb_q   <= '0;
      idx_q   <= '0;
      gt_q    <= 1'b0;
      lt_q    <= 1'b0;
      eq_q    <= 1'b0;
      flags_q <= '0;
    end else begin
      state_q <= state_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      idx_q   <= idx_d;
      gt_q    <= gt_d;
      lt_q    <= lt_d;
      eq_q    <= eq_d;
      flags_q <= flags_d;
    end
  end

  assign req_ready  = (state_q == ST_IDLE);
  assign rsp_valid  = (state_q == ST_DONE);
  assign rsp_gt     = gt_q;
  assign rsp_lt     = lt_q;
  assign rsp_eq     = eq_q;
  assign flags_nzcv = flags_q;

endmodule
